// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the multi-cycle CPU stage sequencer: states, instruction
// classes, the test-opcode pattern and the registered stage-strobe bundle.
package cpu_ctrl_pkg;

  localparam int unsigned STATE_W = 3;
  localparam int unsigned CLASS_W = 3;
  localparam int unsigned OPC_W   = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5
  } state_e;

  localparam logic [CLASS_W-1:0] CLASS_DP_REG = 3'b000;
  localparam logic [CLASS_W-1:0] CLASS_DP_IMM = 3'b001;
  localparam logic [CLASS_W-1:0] CLASS_LDST   = 3'b010;
  localparam logic [CLASS_W-1:0] CLASS_BRANCH = 3'b101;

  // TST/TEQ/CMP/CMN are opcodes 10xx: care bits and their required value
  localparam logic [OPC_W-1:0] OPC_TEST_MASK  = 4'b1100;
  localparam logic [OPC_W-1:0] OPC_TEST_MATCH = 4'b1000;

  typedef struct packed {
    logic fetch_en;
    logic ir_load;
    logic rf_read_en;
    logic alu_en;
    logic mem_req;
    logic rf_we;
    logic flags_we;
    logic link_we;
  } strobe_t;

  function automatic logic is_dp(input logic [CLASS_W-1:0] cls);
    return (cls == CLASS_DP_REG) || (cls == CLASS_DP_IMM);
  endfunction

  function automatic logic is_test_opc(input logic [OPC_W-1:0] opc);
    return (opc & OPC_TEST_MASK) == OPC_TEST_MATCH;
  endfunction

endpackage

// File: rtl/stage_controller_if.sv
// Datapath-facing bundle of the stage sequencer: instruction fields, memory
// handshake, stage strobes and status.
interface stage_controller_if
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
);

  logic               run_i;
  logic [CLASS_W-1:0] inst_class_i;
  logic [OPC_W-1:0]   opcode_i;
  logic               s_bit_i;
  logic               link_i;
  logic               cond_pass_i;
  logic               mem_ready_i;

  logic               fetch_en_o;
  logic               ir_load_o;
  logic               rf_read_en_o;
  logic               alu_en_o;
  logic               mem_req_o;
  logic               mem_we_o;
  logic               rf_we_o;
  logic               flags_we_o;
  logic               link_we_o;
  logic               pc_we_o;
  logic               branch_taken_o;
  logic               busy_o;
  logic [STATE_W-1:0] state_o;
  logic [COUNT_W-1:0] instr_count_o;
  logic               err_o;

  modport master (
    input  run_i, inst_class_i, opcode_i, s_bit_i, link_i, cond_pass_i, mem_ready_i,
    output fetch_en_o, ir_load_o, rf_read_en_o, alu_en_o, mem_req_o, mem_we_o,
           rf_we_o, flags_we_o, link_we_o, pc_we_o, branch_taken_o, busy_o,
           state_o, instr_count_o, err_o
  );

  modport slave (
    output run_i, inst_class_i, opcode_i, s_bit_i, link_i, cond_pass_i, mem_ready_i,
    input  fetch_en_o, ir_load_o, rf_read_en_o, alu_en_o, mem_req_o, mem_we_o,
           rf_we_o, flags_we_o, link_we_o, pc_we_o, branch_taken_o, busy_o,
           state_o, instr_count_o, err_o
  );

endinterface

// File: rtl/stage_controller_mem_wait_timer.sv
// MEMORY-stage wait timer: cleared outside MEMORY, counts while in it, and
// flags expiry in the LIMIT-th wait cycle. Built only with STAGE_CTRL_MEM_TIMEOUT_EN.
`ifdef STAGE_CTRL_MEM_TIMEOUT_EN
module mem_wait_timer #(
  parameter int unsigned LIMIT = 15
) (
  input  logic clk,
  input  logic nreset,
  input  logic load,
  input  logic en,
  output logic expire_c
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt_q;

  assign expire_c = en && (cnt_q == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= '0;
    end else if (en && !expire_c) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/stage_controller.sv
// Multi-cycle FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencer with data-memory
// handshake and retire counter. Optional MEMORY timeout: STAGE_CTRL_MEM_TIMEOUT_EN.
module stage_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned COUNT_W = 16
`ifdef STAGE_CTRL_MEM_TIMEOUT_EN
  , parameter int unsigned MEM_TIMEOUT = 15
`endif
) (
  input  logic               clk,
  input  logic               nreset,
  stage_controller_if.master bus
);

  state_e             state_q, state_d;
  strobe_t            strb_q, strb_d;
  logic               busy_q;
  logic [COUNT_W-1:0] count_q;
  logic               err_q;
  logic               retire_c;
  logic               timeout_c;
  logic               mem_expire_c;
  logic               pc_we_c;
  logic               branch_taken_c;
  logic               mem_we_c;

`ifdef STAGE_CTRL_MEM_TIMEOUT_EN
  mem_wait_timer #(
    .LIMIT (MEM_TIMEOUT)
  ) u_mem_wait_timer (
    .clk      (clk),
    .nreset   (nreset),
    .load     (state_q != MEMORY),
    .en       (state_q == MEMORY),
    .expire_c (mem_expire_c)
  );
`else
  assign mem_expire_c = 1'b0;
`endif

  // Next state, retire/PC controls, and strobes decoded from the state being entered
  always_comb begin
    state_d        = state_q;
    retire_c       = 1'b0;
    timeout_c      = 1'b0;
    pc_we_c        = 1'b0;
    branch_taken_c = 1'b0;
    mem_we_c       = 1'b0;
    strb_d         = '0;

    case (state_q)
      IDLE:    if (bus.run_i && !err_q) state_d = FETCH;
      FETCH:   state_d = DECODE;
      DECODE:  state_d = EXECUTE;
      EXECUTE: begin
        if (!bus.cond_pass_i)                        retire_c = 1'b1;
        else if (bus.inst_class_i == CLASS_LDST)     state_d  = MEMORY;
        else if (is_dp(bus.inst_class_i) ||
                 bus.inst_class_i == CLASS_BRANCH)   state_d  = WRITEBACK;
        else                                         retire_c = 1'b1;
      end
      MEMORY: begin
        mem_we_c = !bus.s_bit_i;
        if (bus.mem_ready_i) begin
          if (bus.s_bit_i) state_d  = WRITEBACK;
          else             retire_c = 1'b1;
        end else if (mem_expire_c) begin
          state_d   = IDLE;
          timeout_c = 1'b1;
        end
      end
      WRITEBACK: begin
        branch_taken_c = (bus.inst_class_i == CLASS_BRANCH);
        retire_c       = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    if (retire_c) begin
      pc_we_c = 1'b1;
      state_d = bus.run_i ? FETCH : IDLE;
    end

    case (state_d)
      FETCH: begin
        strb_d.fetch_en = 1'b1;
        strb_d.ir_load  = 1'b1;
      end
      DECODE:  strb_d.rf_read_en = 1'b1;
      EXECUTE: strb_d.alu_en     = 1'b1;
      MEMORY:  strb_d.mem_req    = 1'b1;
      WRITEBACK: begin
        strb_d.rf_we    = (is_dp(bus.inst_class_i) && !is_test_opc(bus.opcode_i)) ||
                          (bus.inst_class_i == CLASS_LDST);
        strb_d.flags_we = is_dp(bus.inst_class_i) && bus.s_bit_i;
        strb_d.link_we  = (bus.inst_class_i == CLASS_BRANCH) && bus.link_i;
      end
      default: strb_d = '0;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      strb_q  <= '0;
      busy_q  <= 1'b0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      strb_q  <= strb_d;
      busy_q  <= (state_d != IDLE);
      if (retire_c) count_q <= count_q + COUNT_W'(1);
      err_q   <= err_q | timeout_c;
    end
  end

  assign bus.fetch_en_o     = strb_q.fetch_en;
  assign bus.ir_load_o      = strb_q.ir_load;
  assign bus.rf_read_en_o   = strb_q.rf_read_en;
  assign bus.alu_en_o       = strb_q.alu_en;
  assign bus.mem_req_o      = strb_q.mem_req;
  assign bus.rf_we_o        = strb_q.rf_we;
  assign bus.flags_we_o     = strb_q.flags_we;
  assign bus.link_we_o      = strb_q.link_we;
  assign bus.mem_we_o       = mem_we_c;
  assign bus.pc_we_o        = pc_we_c;
  assign bus.branch_taken_o = branch_taken_c;
  assign bus.busy_o         = busy_q;
  assign bus.state_o        = state_q;
  assign bus.instr_count_o  = count_q;
  assign bus.err_o          = err_q;

endmodule

// File: doc/stage_controller.md
Name: stage_controller

Overview:
- Multi-cycle sequencer for the single-issue ARM-subset CPU datapath: code memory, register file, ALU/shifter, flags, data memory and PC.
- Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK.
- Issues one-hot stage strobes that replace the free-running PC/stage counter.
- Handshakes with data memory and counts retired instructions.

Parameters:
- COUNT_W, 16, width of the retired-instruction counter.
- MEM_TIMEOUT, 15, maximum MEMORY wait cycles; used only with the optional feature.

Ports:
- clk  in  1  system clock; all state on rising edge
- nreset  in  1  asynchronous, active-low reset
- run_i  in  1  1 = keep issuing instructions; 0 = stop after current instruction retires
- inst_class_i  in  3  inst[27:25]; valid from DECODE onward
- opcode_i  in  4  inst[24:21]
- s_bit_i  in  1  inst[20]; S bit for data-processing, L bit (1 = load) for load/store
- link_i  in  1  inst[24]; branch-with-link
- cond_pass_i  in  1  condition check result for current instruction (do_jump)
- mem_ready_i  in  1  data memory completed the request
- fetch_en_o  out  1  fetch strobe to code memory
- ir_load_o  out  1  load instruction register
- rf_read_en_o  out  1  register file read
- alu_en_o  out  1  ALU/shifter result capture
- mem_req_o  out  1  data memory request
- mem_we_o  out  1  1 = store, 0 = load; meaningful only while mem_req_o = 1
- rf_we_o  out  1  register file write
- flags_we_o  out  1  NZCV update
- link_we_o  out  1  write PC+4 to r14
- pc_we_o  out  1  PC update
- branch_taken_o  out  1  PC mux selects branch target; meaningful only with pc_we_o
- busy_o  out  1  state != IDLE
- state_o  out  3  current state, for debug ports
- instr_count_o  out  COUNT_W  retired instructions
- err_o  out  1  sticky memory timeout error

Behaviour:
- Reset (asynchronous, immediate, valid mid-instruction):
  - state = IDLE; every output 0; instr_count_o = 0; err_o = 0.
  - No partial write-back is completed.
- Outputs are registered Moore decodes of state. Exception: pc_we_o, branch_taken_o and mem_we_o are combinational from state plus inputs.
- IDLE: run_i = 1 -> FETCH; otherwise stay.
- FETCH: fetch_en_o = 1, ir_load_o = 1; -> DECODE.
- DECODE: rf_read_en_o = 1; -> EXECUTE.
- EXECUTE: alu_en_o = 1. Next state:
  - cond_pass_i = 0 -> retire.
  - class 010 -> MEMORY.
  - class 000/001/101 -> WRITEBACK.
  - any other class -> retire (NOP).
- MEMORY:
  - mem_req_o = 1 and mem_we_o = !s_bit_i, held stable until the cycle mem_ready_i = 1.
  - On ready: load -> WRITEBACK; store -> retire.
  - mem_ready_i outside MEMORY is ignored.
- WRITEBACK:
  - rf_we_o = 1 for class 000/001 unless opcode_i is 10xx (TST/TEQ/CMP/CMN).
  - rf_we_o = 1 for every load.
  - flags_we_o = s_bit_i for class 000/001 only.
  - Branch: link_we_o = link_i, branch_taken_o = 1, no rf_we_o.
  - Then retire.
- Retire, applied in the last cycle of the instruction:
  - pc_we_o = 1; branch_taken_o = 1 only for a taken branch.
  - instr_count_o increments, wrapping at 2^COUNT_W.
  - Next state FETCH if run_i = 1, else IDLE.
- Latency, FETCH to retire inclusive:
  - condition fail / NOP: 3 cycles
  - data-processing, branch: 4
  - store: 4 + wait cycles
  - load: 5 + wait cycles
- run_i falling mid-instruction: the instruction completes normally, then IDLE.
- Exactly one of fetch_en_o, rf_read_en_o, alu_en_o, mem_req_o, rf_we_o/link_we_o-stage is active per cycle.

Optional Feature:
- STAGE_CTRL_MEM_TIMEOUT_EN defined:
  - A counter runs while in MEMORY.
  - If MEM_TIMEOUT cycles pass without mem_ready_i, mem_req_o drops and err_o sets.
  - State -> IDLE with no pc_we_o and no count increment.
  - err_o is sticky until reset. While err_o = 1, run_i is ignored.
- Undefined: MEMORY waits indefinitely; err_o tied 0.

Decomposition:
- Package cpu_ctrl_pkg:
  - state encoding: IDLE = 0, FETCH = 1, DECODE = 2, EXECUTE = 3, MEMORY = 4, WRITEBACK = 5
  - class constants: CLASS_DP_REG = 000, CLASS_DP_IMM = 001, CLASS_LDST = 010, CLASS_BRANCH = 101
  - OPC_TEST_MASK = 10xx
- One sub-module: mem_wait_timer (load/count/expire). Instantiated only under the macro.

Test Plan:
- ADD with S = 1, cond pass, run_i held 1 -> FETCH..WRITEBACK in 4 cycles; rf_we_o = 1, flags_we_o = 1, pc_we_o = 1 in cycle 4; count 0 -> 1.
- CMP (opcode 1010, S = 1) -> rf_we_o never asserted; flags_we_o = 1.
- Load with mem_ready_i after 3 wait cycles -> mem_req_o high 4 cycles, mem_we_o = 0, WRITEBACK rf_we_o = 1; total 8 cycles.
- BL taken (class 101, link_i = 1, cond_pass_i = 1) -> link_we_o = 1, branch_taken_o = 1 with pc_we_o.
- Branch with cond_pass_i = 0 -> retire after EXECUTE (3 cycles), branch_taken_o = 0.
- nreset low during MEMORY -> all outputs 0 immediately, state_o = 0.
- With macro defined, MEM_TIMEOUT = 15 and no ready -> err_o = 1 after 15 cycles, state IDLE, count unchanged.
